mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute datapath.
- Consumes the execute result: opcode, funct3, effective address, ALU result or store data, and destination register index.
- Performs load/store transactions on the data-memory port, with a request/grant/response handshake and variable latency, and does byte-lane steering and load extension.
- Presents write-back data plus a forwarding value back to the datapath, and stalls the front of the pipe while a transaction is outstanding.

---
 rtl/rv_pkg.sv | 51 +++++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/mem_access_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the memory-access stage: opcodes, load/store size codes,
// FSM states and helpers for access-size decoding and low-address alignment.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W
  } size_t;

  // Reserved encodings (x11, 110) fall through to word.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SIZE_B;
      2'b01:   return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (size_of(f3))
      SIZE_B:  return lo;
      SIZE_H:  return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (size_of(f3))
      SIZE_H:  return lo[0];
      SIZE_W:  return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (enables + replicated data) and lane extraction
// with sign/zero extension for loads. Purely combinational.
module mem_lane_align
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  logic [15:0] lane;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (size_of(st_funct3))
      SIZE_B: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        st_be    = 4'b0011 << st_addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Selected lane lands in the low bits; extension then works on a fixed position.
  always_comb begin
    lane = 16'(ld_word >> {ld_addr_lo, 3'b000});
    case (ld_funct3)
      F3_LB:   ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_LH:   ld_data = {{(XLEN-16){lane[15]}}, lane};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, lane};
      F3_LW:   ld_data = ld_word;
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: load/store over a req/gnt/rvalid port with timeout.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_stage
  import rv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [6:0]      dp_ctrl,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rd_addr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] mem_forward,
  output logic            stall,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic            bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       f3_p1;
  logic [1:0]       alo_p1;
  logic [4:0]       rd_p1;

  logic             is_mem, trap, capture;
  logic             ret_alu, ret_trap, ret_store, ret_load, ret_tmo;
  logic             ret_any, ret_wen;
  logic [1:0]       alo_in;
  logic [3:0]       be_in;
  logic [XLEN-1:0]  wdata_in, ld_data;

  assign is_mem = (dp_ctrl == OPC_LOAD) || (dp_ctrl == OPC_STORE);
  assign alo_in = align_lo(funct3, mem_addr[1:0]);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = is_mem && misaligned(funct3, mem_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_lane (
    .st_funct3 (funct3),
    .st_addr_lo(alo_in),
    .st_data   (wr_data),
    .st_be     (be_in),
    .st_wdata  (wdata_in),
    .ld_funct3 (f3_p1),
    .ld_addr_lo(alo_p1),
    .ld_word   (dmem_rdata),
    .ld_data   (ld_data)
  );

  assign stall    = (state != IDLE);
  assign ex_ready = !stall;
  assign dmem_req = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ret_alu   = 1'b0;
    ret_trap  = 1'b0;
    ret_store = 1'b0;
    ret_load  = 1'b0;
    ret_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            ret_alu = 1'b1;
          end else if (trap) begin
            ret_trap = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (dmem_we) begin
            ret_store = 1'b1;
            state_nxt = IDLE;
          end else if (dmem_rvalid) begin
            // Zero-latency response: retire directly, WAIT is never entered.
            ret_load  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          ret_load  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ret_tmo   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ret_any = ret_alu | ret_trap | ret_store | ret_load | ret_tmo;
  assign ret_wen = (ret_alu && (rd_addr != 5'd0)) || (ret_load && (rd_p1 != 5'd0));

  // p1: access context held for the lifetime of the transaction
  always_ff @(posedge clk) begin
    if (capture) begin
      f3_p1  <= funct3;
      alo_p1 <= alo_in;
      rd_p1  <= rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= 4'b0000;
      cnt         <= '0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
      mem_forward <= '0;
      bus_err     <= 1'b0;
    end else begin
      wb_valid <= ret_any;
      wb_en    <= ret_wen;
      bus_err  <= ret_tmo;
      if (capture) begin
        dmem_we    <= (dp_ctrl == OPC_STORE);
        dmem_addr  <= {mem_addr[XLEN-1:2], 2'b00};
        dmem_wdata <= wdata_in;
        dmem_be    <= be_in;
      end
      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (ret_any) wb_rd <= (ret_alu || ret_trap) ? rd_addr : rd_p1;
      if (ret_alu)       wb_data <= wr_data;
      else if (ret_load) wb_data <= ld_data;
      if (ret_wen) mem_forward <= ret_alu ? wr_data : ld_data;
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= ret_trap;
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized load/store/ALU traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TMO = 64;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [6:0]  dp_ctrl = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_forward;
  logic        stall, bus_err;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .dp_ctrl(dp_ctrl), .funct3(funct3), .mem_addr(mem_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .mem_forward(mem_forward),
    .stall(stall),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] fwd_model = 32'd0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, naturally aligned lane offset.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int eff_lo(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return 4'(((1 << n) - 1) << eff_lo(f3, a));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(f3);
    if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int n = nbytes(f3);
    int lo = eff_lo(f3, a);
    logic [31:0] v;
    if (n == 4) return w;
    v = (w >> (8 * lo)) & ((32'd1 << (8 * n)) - 32'd1);
    if (!f3[2] && (v >= (32'd1 << (8 * n - 1)))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic chk_reset_outputs(input string pfx);
    chk1({pfx, "_req"}, dmem_req, 1'b0);
    chk1({pfx, "_we"}, dmem_we, 1'b0);
    chk32({pfx, "_addr"}, dmem_addr, 32'd0);
    chk32({pfx, "_wdata"}, dmem_wdata, 32'd0);
    chk32({pfx, "_be"}, 32'(dmem_be), 32'd0);
    chk1({pfx, "_wbv"}, wb_valid, 1'b0);
    chk1({pfx, "_wben"}, wb_en, 1'b0);
    chk32({pfx, "_wbrd"}, 32'(wb_rd), 32'd0);
    chk32({pfx, "_wbdata"}, wb_data, 32'd0);
    chk32({pfx, "_fwd"}, mem_forward, 32'd0);
    chk1({pfx, "_stall"}, stall, 1'b0);
    chk1({pfx, "_berr"}, bus_err, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk1("idle_wbv", wb_valid, 1'b0);
      chk1("idle_berr", bus_err, 1'b0);
      chk1("idle_stall", stall, 1'b0);
    end
  endtask

  task automatic do_alu(input logic [31:0] res, input logic [4:0] rd);
    chk1("alu_ready", ex_ready, 1'b1);
    ex_valid = 1'b1; dp_ctrl = OP_ALU; funct3 = 3'($urandom);
    mem_addr = $urandom; wr_data = res; rd_addr = rd;
    @(negedge clk);
    ex_valid = 1'b0;
    if (rd != 5'd0) fwd_model = res;
    chk1("alu_wbv", wb_valid, 1'b1);
    chk1("alu_wben", wb_en, rd != 5'd0);
    chk32("alu_wbrd", 32'(wb_rd), 32'(rd));
    chk32("alu_wbdata", wb_data, res);
    chk32("alu_fwd", mem_forward, fwd_model);
    chk1("alu_stall", stall, 1'b0);
    chk1("alu_req", dmem_req, 1'b0);
  endtask

  // rv_dly: 0 = rvalid with gnt, >0 = cycles after gnt, <0 = never (timeout)
  task automatic do_mem(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    logic [31:0] eld;
    chk1("mem_ready", ex_ready, 1'b1);
    ex_valid = 1'b1; dp_ctrl = store ? OP_STORE : OP_LOAD; funct3 = f3;
    mem_addr = addr; wr_data = data; rd_addr = rd;
    @(negedge clk);
    ex_valid = 1'b0; dp_ctrl = 7'd0; wr_data = $urandom; mem_addr = $urandom;
    for (int i = 0; i <= gnt_dly; i++) begin
      chk1("req_stall", stall, 1'b1);
      chk1("req_ready", ex_ready, 1'b0);
      chk1("req_req", dmem_req, 1'b1);
      chk1("req_we", dmem_we, store);
      chk32("req_addr", dmem_addr, {addr[31:2], 2'b00});
      chk32("req_be", 32'(dmem_be), 32'(exp_be(f3, addr)));
      if (store) chk32("req_wdata", dmem_wdata, exp_wdata(f3, data));
      if (i < gnt_dly) @(negedge clk);
    end
    dmem_gnt = 1'b1;
    if (!store && rv_dly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    if (!store && rv_dly != 0) begin
      if (rv_dly > 0) begin
        for (int i = 1; i < rv_dly; i++) begin
          chk1("wait_stall", stall, 1'b1);
          chk1("wait_req", dmem_req, 1'b0);
          chk1("wait_wbv", wb_valid, 1'b0);
          @(negedge clk);
          dmem_rdata = $urandom;
        end
        chk1("wait_stall", stall, 1'b1);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end else begin
        for (int i = 0; i < TMO; i++) begin
          chk1("tmo_stall", stall, 1'b1);
          chk1("tmo_berr", bus_err, 1'b0);
          @(negedge clk);
        end
      end
    end
    chk1("ret_wbv", wb_valid, 1'b1);
    chk1("ret_stall", stall, 1'b0);
    chk1("ret_ready", ex_ready, 1'b1);
    chk1("ret_req", dmem_req, 1'b0);
    chk1("ret_berr", bus_err, !store && rv_dly < 0);
    if (store || rv_dly < 0) begin
      chk1("ret_wben", wb_en, 1'b0);
    end else begin
      eld = exp_load(f3, addr, rdata);
      if (rd != 5'd0) fwd_model = eld;
      chk1("ld_wben", wb_en, rd != 5'd0);
      chk32("ld_wbrd", 32'(wb_rd), 32'(rd));
      chk32("ld_wbdata", wb_data, eld);
    end
    chk32("ret_fwd", mem_forward, fwd_model);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, gd, rv;
    bit st;
    logic [2:0] f3;
    logic [31:0] a, d, rdat;
    logic [4:0] rd;

    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    idle(1);

    // ALU result, single-cycle write-back
    do_alu(32'h0000_0005, 5'd3);
    idle(1);

    // SB to top byte lane, grant after two cycles
    do_mem(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 2, 0, 32'd0);
    idle(1);

    // LB / LBU from lane 1, response three cycles after grant
    do_mem(1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd5, 1, 3, 32'h0000_8000);
    idle(1);
    do_mem(1'b0, 3'b100, 32'h0000_2001, 32'd0, 5'd6, 0, 3, 32'h0000_8000);

    // LW with same-cycle gnt/rvalid, ADD issued in the retire cycle
    do_mem(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd7, 0, 0, 32'hDEAD_BEEF);
    do_alu(32'h1234_5678, 5'd8);
    idle(1);

    // LW that never answers
    do_mem(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd9, 0, -1, 32'd0);
    idle(1);

    // Reset while waiting for a response, then a stale rvalid
    ex_valid = 1'b1; dp_ctrl = OP_LOAD; funct3 = 3'b010; mem_addr = 32'h0000_6004; rd_addr = 5'd10;
    @(negedge clk);
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rstw_stall_before", stall, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rstw");
    fwd_model = 32'd0;
    @(negedge clk);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk1("late_rv_wbv", wb_valid, 1'b0);
    chk1("late_rv_stall", stall, 1'b0);
    chk32("late_rv_fwd", mem_forward, 32'd0);

    // Misaligned LH
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ex_valid = 1'b1; dp_ctrl = OP_LOAD; funct3 = 3'b001; mem_addr = 32'h0000_3001; rd_addr = 5'd4;
    @(negedge clk);
    ex_valid = 1'b0;
    chk1("mis_err", misalign_err, 1'b1);
    chk1("mis_req", dmem_req, 1'b0);
    chk1("mis_wbv", wb_valid, 1'b1);
    chk1("mis_wben", wb_en, 1'b0);
    chk1("mis_stall", stall, 1'b0);
    @(negedge clk);
    chk1("mis_err_pulse", misalign_err, 1'b0);
    chk1("mis_req_after", dmem_req, 1'b0);
`else
    do_mem(1'b0, 3'b001, 32'h0000_3001, 32'd0, 5'd4, 1, 1, 32'h8001_7F02);
    chk32("mis_be_masked", 32'(dmem_be), 32'h0000_0003);
    chk32("mis_addr", dmem_addr, 32'h0000_3000);
`endif
    idle(1);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      a = $urandom; d = $urandom; rdat = $urandom;
      rd = 5'($urandom_range(0, 31));
      gd = $urandom_range(0, 3);
      rv = $urandom_range(0, 6);
      if (kind == 0) begin
        do_alu(d, rd);
      end else begin
        st = (kind == 2);
        f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        a[1:0] = 2'(eff_lo(f3, a));
`endif
        do_mem(st, f3, a, d, rd, gd, rv, rdat);
      end
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
